// File: rtl/crf_pkg.sv
// Shared definitions for the configuration register bank: register map,
// AXI response codes, UPSTAT bit positions and address/strobe helpers.
package crf_pkg;

    localparam logic [31:0] ADDR_UPSTAT     = 32'h0000_0000;
    localparam logic [31:0] ADDR_INTEN      = 32'h0000_0004;
    localparam logic [31:0] ADDR_INTSTAT    = 32'h0000_0008;
    localparam logic [31:0] ADDR_PROCCNT    = 32'h0000_000C;
    localparam logic [31:0] ADDR_CNT_BASE   = 32'h0000_0010;
    localparam logic [31:0] ADDR_CNT_STRIDE = 32'h0000_0008;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    localparam int UPSTAT_START_BIT = 0;
    localparam int UPSTAT_END_BIT   = 1;

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_UPSTAT,
        SEL_INTEN,
        SEL_INTSTAT,
        SEL_PROCCNT,
        SEL_HSK,
        SEL_NRDY
    } reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [2:0] ch;
    } reg_dec_t;

    // Byte address to register select; the two lowest address bits are don't-care.
    function automatic reg_dec_t decode_addr(input logic [63:0] byte_addr,
                                             input int unsigned num_ch);
        reg_dec_t   d;
        logic [63:0] a;
        logic [63:0] ofs;
        a     = byte_addr & ~64'd3;
        d.sel = SEL_NONE;
        d.ch  = 3'd0;
        ofs   = 64'd0;
        if (a == 64'(ADDR_UPSTAT)) begin
            d.sel = SEL_UPSTAT;
        end else if (a == 64'(ADDR_INTEN)) begin
            d.sel = SEL_INTEN;
        end else if (a == 64'(ADDR_INTSTAT)) begin
            d.sel = SEL_INTSTAT;
        end else if (a == 64'(ADDR_PROCCNT)) begin
            d.sel = SEL_PROCCNT;
        end else if ((a >= 64'(ADDR_CNT_BASE)) &&
                     (a < (64'(ADDR_CNT_BASE) + 64'(num_ch) * 64'(ADDR_CNT_STRIDE)))) begin
            ofs   = a - 64'(ADDR_CNT_BASE);
            d.ch  = 3'(ofs >> 3);
            d.sel = ((ofs & 64'd4) != 64'd0) ? SEL_NRDY : SEL_HSK;
        end else begin
            d.sel = SEL_NONE;
        end
        return d;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int b = 0; b < 4; b++) begin
            res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/crf_perf_counter.sv
// Saturating performance counter: counts while running, holds or clears
// when idle depending on the hold request.
module crf_perf_counter #(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_run,
    input  logic                 i_hold,
    input  logic                 i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_count_nxt;

    // Next count: run increments up to the ceiling, idle either holds or clears.
    always_comb begin
        w_count_nxt = r_count;
        if (i_run) begin
            if (i_inc && (r_count != CNT_MAX)) begin
                w_count_nxt = r_count + CNT_ONE;
            end else begin
                w_count_nxt = r_count;
            end
        end else if (i_hold) begin
            w_count_nxt = r_count;
        end else begin
            w_count_nxt = {CNT_WIDTH{1'b0}};
        end
    end

    // Count register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CNT_WIDTH{1'b0}};
        end else begin
            r_count <= w_count_nxt;
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/config_register_bank.sv
// AXI4-Lite configuration/status register bank with PL-side UPSTAT write,
// edge-triggered interrupt and per-channel stream performance counters.
module config_register_bank
    import crf_pkg::*;
#(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int NUM_CH         = 2,
    parameter int CNT_WIDTH      = 32
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_axi_awvalid,
    output logic                        s_axi_awready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_awaddr,
    input  logic [2:0]                  s_axi_awprot,
    input  logic                        s_axi_wvalid,
    output logic                        s_axi_wready,
    input  logic [AXI_DATA_WIDTH-1:0]   s_axi_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0] s_axi_wstrb,
    output logic                        s_axi_bvalid,
    input  logic                        s_axi_bready,
    output logic [1:0]                  s_axi_bresp,
    input  logic                        s_axi_arvalid,
    output logic                        s_axi_arready,
    input  logic [AXI_ADDR_WIDTH-1:0]   s_axi_araddr,
    input  logic [2:0]                  s_axi_arprot,
    output logic                        s_axi_rvalid,
    input  logic                        s_axi_rready,
    output logic [AXI_DATA_WIDTH-1:0]   s_axi_rdata,
    output logic [1:0]                  s_axi_rresp,
    input  logic                        pl_wrt,
    input  logic [31:0]                 pl_wdata,
    output logic                        pl_wbusy,
    input  logic [NUM_CH-1:0]           ch_tvalid,
    input  logic [NUM_CH-1:0]           ch_tready,
    input  logic                        processing,
    output logic                        up_start,
    output logic                        up_end,
    output logic                        irq
);

    logic                      r_aw_held;
    logic [AXI_ADDR_WIDTH-1:0] r_aw_addr;
    logic                      r_w_held;
    logic [31:0]               r_w_data;
    logic [3:0]                r_w_strb;
    logic                      r_bvalid;
    logic [1:0]                r_bresp;
    logic                      r_defer;
    logic                      r_rvalid;
    logic [31:0]               r_rdata;
    logic [1:0]                r_rresp;
    logic [31:0]               r_upstat;
    logic                      r_inten;
    logic                      r_intstat;

    logic        w_aw_hs, w_w_hs, w_ar_hs;
    logic        w_pl_take, w_both_held, w_commit, w_wr_ok;
    reg_dec_t    w_wr_dec, w_ar_dec;
    logic [31:0] w_upstat_nxt;
    logic        w_inten_nxt, w_intstat_nxt, w_int_set, w_int_clr;
    logic [31:0] w_rd_data;
    logic [1:0]  w_rd_resp;
    logic        w_up_start, w_up_end;
    logic        w_unused;

    logic [CNT_WIDTH-1:0] w_hsk_cnt  [8];
    logic [CNT_WIDTH-1:0] w_nrdy_cnt [8];
    logic [CNT_WIDTH-1:0] w_proc_cnt;

    assign s_axi_awready = rst_n & ~r_aw_held & ~r_bvalid;
    assign s_axi_wready  = rst_n & ~r_w_held & ~r_bvalid;
    assign s_axi_arready = rst_n & ~r_rvalid;
    assign s_axi_bvalid  = r_bvalid;
    assign s_axi_bresp   = r_bresp;
    assign s_axi_rvalid  = r_rvalid;
    assign s_axi_rdata   = r_rdata;
    assign s_axi_rresp   = r_rresp;

    assign w_aw_hs = s_axi_awvalid & s_axi_awready;
    assign w_w_hs  = s_axi_wvalid & s_axi_wready;
    assign w_ar_hs = s_axi_arvalid & s_axi_arready;

    // A deferred commit keeps the PL port busy so the AXI write lands next cycle.
    assign pl_wbusy    = r_bvalid | r_defer;
    assign w_pl_take   = pl_wrt & ~pl_wbusy;
    assign w_both_held = r_aw_held & r_w_held;
    assign w_commit    = w_both_held & ~w_pl_take;

    assign w_wr_dec = decode_addr(64'(r_aw_addr), NUM_CH);
    assign w_ar_dec = decode_addr(64'(s_axi_araddr), NUM_CH);
    assign w_wr_ok  = (w_wr_dec.sel == SEL_UPSTAT) || (w_wr_dec.sel == SEL_INTEN) ||
                      (w_wr_dec.sel == SEL_INTSTAT);

    assign w_up_start = r_upstat[UPSTAT_START_BIT];
    assign w_up_end   = r_upstat[UPSTAT_END_BIT];
    assign up_start   = w_up_start;
    assign up_end     = w_up_end;
    assign irq        = r_intstat & r_inten;

    assign w_unused = &{1'b0, s_axi_awprot, s_axi_arprot, w_wr_dec.ch};

    // Next register values from PL and AXI writes; an interrupt set beats a clear.
    always_comb begin
        w_upstat_nxt = r_upstat;
        w_inten_nxt  = r_inten;
        w_int_clr    = 1'b0;
        if (w_pl_take) begin
            w_upstat_nxt = pl_wdata;
        end else if (w_commit && (w_wr_dec.sel == SEL_UPSTAT)) begin
            w_upstat_nxt = apply_wstrb(r_upstat, r_w_data, r_w_strb);
        end else begin
            w_upstat_nxt = r_upstat;
        end
        if (w_commit && (w_wr_dec.sel == SEL_INTEN) && r_w_strb[0]) begin
            w_inten_nxt = r_w_data[0];
        end else begin
            w_inten_nxt = r_inten;
        end
        if (w_commit && (w_wr_dec.sel == SEL_INTSTAT) && r_w_strb[0]) begin
            w_int_clr = r_w_data[0];
        end else begin
            w_int_clr = 1'b0;
        end
        w_int_set     = w_upstat_nxt[UPSTAT_END_BIT] & ~r_upstat[UPSTAT_END_BIT];
        w_intstat_nxt = w_int_set | (r_intstat & ~w_int_clr);
    end

    // Read data mux; counters are zero-extended.
    always_comb begin
        w_rd_data = 32'd0;
        w_rd_resp = RESP_OKAY;
        case (w_ar_dec.sel)
            SEL_UPSTAT:  w_rd_data = r_upstat;
            SEL_INTEN:   w_rd_data = {31'd0, r_inten};
            SEL_INTSTAT: w_rd_data = {31'd0, r_intstat};
            SEL_PROCCNT: w_rd_data = 32'(w_proc_cnt);
            SEL_HSK:     w_rd_data = 32'(w_hsk_cnt[w_ar_dec.ch]);
            SEL_NRDY:    w_rd_data = 32'(w_nrdy_cnt[w_ar_dec.ch]);
            default: begin
                w_rd_data = 32'd0;
                w_rd_resp = RESP_SLVERR;
            end
        endcase
    end

    // Write address/data holding registers and write response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_aw_held <= 1'b0;
            r_aw_addr <= {AXI_ADDR_WIDTH{1'b0}};
            r_w_held  <= 1'b0;
            r_w_data  <= 32'd0;
            r_w_strb  <= 4'd0;
            r_bvalid  <= 1'b0;
            r_bresp   <= RESP_OKAY;
            r_defer   <= 1'b0;
        end else begin
            r_defer <= w_both_held & w_pl_take;
            if (w_aw_hs) begin
                r_aw_held <= 1'b1;
                r_aw_addr <= s_axi_awaddr;
            end else if (w_commit) begin
                r_aw_held <= 1'b0;
            end
            if (w_w_hs) begin
                r_w_held <= 1'b1;
                r_w_data <= s_axi_wdata;
                r_w_strb <= s_axi_wstrb;
            end else if (w_commit) begin
                r_w_held <= 1'b0;
            end
            if (w_commit) begin
                r_bvalid <= 1'b1;
                r_bresp  <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (r_bvalid && s_axi_bready) begin
                r_bvalid <= 1'b0;
            end
        end
    end

    // Read channel: data is captured at the address handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rvalid <= 1'b0;
            r_rdata  <= 32'd0;
            r_rresp  <= RESP_OKAY;
        end else if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rdata  <= w_rd_data;
            r_rresp  <= w_rd_resp;
        end else if (r_rvalid && s_axi_rready) begin
            r_rvalid <= 1'b0;
        end
    end

    // Architectural registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_upstat  <= 32'd0;
            r_inten   <= 1'b0;
            r_intstat <= 1'b0;
        end else begin
            r_upstat  <= w_upstat_nxt;
            r_inten   <= w_inten_nxt;
            r_intstat <= w_intstat_nxt;
        end
    end

    crf_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_proc_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_run   (processing),
        .i_hold  (w_up_end),
        .i_inc   (1'b1),
        .o_count (w_proc_cnt)
    );

    for (genvar g = 0; g < 8; g++) begin : g_ch
        if (g < NUM_CH) begin : g_on
            crf_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_hsk_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_run   (processing),
                .i_hold  (w_up_end),
                .i_inc   (w_up_start & ch_tvalid[g] & ch_tready[g]),
                .o_count (w_hsk_cnt[g])
            );
            crf_perf_counter #(.CNT_WIDTH(CNT_WIDTH)) u_nrdy_cnt (
                .clk     (clk),
                .rst_n   (rst_n),
                .i_run   (processing),
                .i_hold  (w_up_end),
                .i_inc   (w_up_start & ch_tvalid[g] & ~ch_tready[g]),
                .o_count (w_nrdy_cnt[g])
            );
        end else begin : g_off
            assign w_hsk_cnt[g]  = {CNT_WIDTH{1'b0}};
            assign w_nrdy_cnt[g] = {CNT_WIDTH{1'b0}};
        end
    end

endmodule

// File: tb/tb_config_register_bank.sv
// Scoreboard bench for config_register_bank: stimulus queues expected AXI
// responses, a negedge monitor pops and compares them on each handshake.
module tb_config_register_bank;
    import crf_pkg::*;

    localparam int NUM_CH    = 2;
    localparam int CNT_WIDTH = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        pl_wrt, pl_wbusy;
    logic [31:0] pl_wdata;
    logic [NUM_CH-1:0] ch_tvalid, ch_tready;
    logic        processing, up_start, up_end, irq;

    int n_checks = 0;
    int n_errors = 0;

    logic [1:0]  exp_b_q [$];
    string       exp_b_nm [$];
    logic [33:0] exp_r_q [$];
    string       exp_r_nm [$];

    always #5 clk = ~clk;

    config_register_bank #(
        .AXI_DATA_WIDTH(32), .AXI_ADDR_WIDTH(32), .NUM_CH(NUM_CH), .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready), .s_axi_bresp(s_axi_bresp),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .pl_wrt(pl_wrt), .pl_wdata(pl_wdata), .pl_wbusy(pl_wbusy),
        .ch_tvalid(ch_tvalid), .ch_tready(ch_tready), .processing(processing),
        .up_start(up_start), .up_end(up_end), .irq(irq)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Response monitor: compares each B/R handshake against the queued expectation.
    always @(negedge clk) begin : mon
        logic [1:0]  eb;
        logic [33:0] er;
        string       nm;
        if (rst_n === 1'b1) begin
            if (s_axi_bvalid && s_axi_bready) begin
                if (exp_b_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL b_unexpected: got bresp %0d, expected no response", s_axi_bresp);
                end else begin
                    eb = exp_b_q.pop_front();
                    nm = exp_b_nm.pop_front();
                    check(nm, {30'd0, s_axi_bresp}, {30'd0, eb});
                end
            end
            if (s_axi_rvalid && s_axi_rready) begin
                if (exp_r_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL r_unexpected: got rdata 0x%08h, expected no response", s_axi_rdata);
                end else begin
                    er = exp_r_q.pop_front();
                    nm = exp_r_nm.pop_front();
                    check(nm, s_axi_rdata, er[31:0]);
                    check({nm, "_resp"}, {30'd0, s_axi_rresp}, {30'd0, er[33:32]});
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_aw(input logic [31:0] a);
        int n;
        n = 0;
        s_axi_awaddr  = a;
        s_axi_awvalid = 1'b1;
        while (!s_axi_awready && n < 50) begin
            tick();
            n++;
        end
        check("aw_accept", {31'd0, s_axi_awready}, 32'd1);
        tick();
        s_axi_awvalid = 1'b0;
    endtask

    task automatic do_w(input logic [31:0] d, input logic [3:0] s);
        int n;
        n = 0;
        s_axi_wdata  = d;
        s_axi_wstrb  = s;
        s_axi_wvalid = 1'b1;
        while (!s_axi_wready && n < 50) begin
            tick();
            n++;
        end
        check("w_accept", {31'd0, s_axi_wready}, 32'd1);
        tick();
        s_axi_wvalid = 1'b0;
    endtask

    task automatic wait_b(input string nm);
        int n;
        n = 0;
        while (exp_b_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check({nm, "_done"}, exp_b_q.size(), 32'd0);
        exp_b_q.delete();
        exp_b_nm.delete();
    endtask

    task automatic axi_write(input string nm, input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, input logic [1:0] resp);
        exp_b_q.push_back(resp);
        exp_b_nm.push_back(nm);
        fork
            do_aw(a);
            do_w(d, s);
        join
        wait_b(nm);
    endtask

    task automatic axi_read(input string nm, input logic [31:0] a, input logic [31:0] d,
                            input logic [1:0] resp);
        int n;
        n = 0;
        exp_r_q.push_back({resp, d});
        exp_r_nm.push_back(nm);
        s_axi_araddr  = a;
        s_axi_arvalid = 1'b1;
        while (!s_axi_arready && n < 50) begin
            tick();
            n++;
        end
        check({nm, "_ar"}, {31'd0, s_axi_arready}, 32'd1);
        tick();
        s_axi_arvalid = 1'b0;
        n = 0;
        while (exp_r_q.size() != 0 && n < 50) begin
            tick();
            n++;
        end
        check({nm, "_done"}, exp_r_q.size(), 32'd0);
        exp_r_q.delete();
        exp_r_nm.delete();
    endtask

    initial begin
        int n;
        s_axi_awvalid = 1'b0; s_axi_awaddr = 32'd0; s_axi_awprot = 3'b101;
        s_axi_wvalid  = 1'b0; s_axi_wdata  = 32'd0; s_axi_wstrb  = 4'd0;
        s_axi_bready  = 1'b1;
        s_axi_arvalid = 1'b0; s_axi_araddr = 32'd0; s_axi_arprot = 3'b010;
        s_axi_rready  = 1'b1;
        pl_wrt = 1'b0; pl_wdata = 32'd0;
        ch_tvalid = 2'b00; ch_tready = 2'b00; processing = 1'b0;

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        tick();

        // Reset state
        check("rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        check("rst_rvalid", {31'd0, s_axi_rvalid}, 32'd0);
        check("rst_irq", {31'd0, irq}, 32'd0);
        check("rst_wbusy", {31'd0, pl_wbusy}, 32'd0);
        check("rst_awready", {31'd0, s_axi_awready}, 32'd1);
        axi_read("rst_upstat", 32'h00, 32'd0, RESP_OKAY);
        axi_read("rst_inten", 32'h04, 32'd0, RESP_OKAY);
        axi_read("rst_intstat", 32'h08, 32'd0, RESP_OKAY);
        axi_read("rst_proccnt", 32'h0C, 32'd0, RESP_OKAY);

        // W two cycles ahead of AW; response one cycle after AW capture
        s_axi_wdata = 32'd1; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_wvalid = 1'b0;
        tick();
        exp_b_q.push_back(RESP_OKAY);
        exp_b_nm.push_back("early_w_bresp");
        s_axi_awaddr = 32'h04; s_axi_awvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0;
        check("early_w_b_not_yet", {31'd0, s_axi_bvalid}, 32'd0);
        tick();
        check("early_w_b_lat", {31'd0, s_axi_bvalid}, 32'd1);
        wait_b("early_w");
        axi_read("inten_rd", 32'h04, 32'd1, RESP_OKAY);

        // Byte strobes
        axi_write("upstat_3", 32'h00, 32'h0000_0003, 4'hF, RESP_OKAY);
        check("irq_on_end_edge", {31'd0, irq}, 32'd1);
        check("up_start_1", {31'd0, up_start}, 32'd1);
        axi_write("upstat_strb2", 32'h00, 32'h0000_AB00, 4'h2, RESP_OKAY);
        axi_read("upstat_strb_rd", 32'h00, 32'h0000_AB03, RESP_OKAY);

        // Clear UPSTAT, then W1C INTSTAT using an address with low bits set
        axi_write("upstat_0", 32'h00, 32'h0, 4'hF, RESP_OKAY);
        axi_write("intstat_w1c", 32'h0B, 32'h1, 4'h1, RESP_OKAY);
        check("irq_cleared", {31'd0, irq}, 32'd0);
        axi_read("intstat_rd0", 32'h08, 32'd0, RESP_OKAY);

        // PL write colliding with the AXI commit cycle
        exp_b_q.push_back(RESP_OKAY);
        exp_b_nm.push_back("pl_coll_bresp");
        s_axi_awaddr = 32'h00; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h5; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        check("pl_coll_wbusy0", {31'd0, pl_wbusy}, 32'd0);
        pl_wrt = 1'b1; pl_wdata = 32'h2;
        tick();
        pl_wrt = 1'b0;
        check("pl_first_end", {31'd0, up_end}, 32'd1);
        check("pl_first_start", {31'd0, up_start}, 32'd0);
        check("pl_irq", {31'd0, irq}, 32'd1);
        check("pl_coll_bvalid0", {31'd0, s_axi_bvalid}, 32'd0);
        check("pl_coll_wbusy1", {31'd0, pl_wbusy}, 32'd1);
        tick();
        check("axi_second_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        check("axi_second_start", {31'd0, up_start}, 32'd1);
        check("axi_second_end", {31'd0, up_end}, 32'd0);
        wait_b("pl_coll");
        axi_read("pl_coll_upstat", 32'h00, 32'h5, RESP_OKAY);

        // 10 processing cycles, ch0 always ready, ch1 never ready; up_end raised mid-run
        axi_write("upstat_start", 32'h00, 32'h1, 4'hF, RESP_OKAY);
        processing = 1'b1; ch_tvalid = 2'b11; ch_tready = 2'b01;
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 5) begin
                pl_wrt = 1'b1; pl_wdata = 32'h3;
            end else begin
                pl_wrt = 1'b0;
            end
        end
        processing = 1'b0;
        check("hold_up_end", {31'd0, up_end}, 32'd1);
        axi_read("hsk0_10", 32'h10, 32'd10, RESP_OKAY);
        axi_read("hsk0_lowbits", 32'h12, 32'd10, RESP_OKAY);
        axi_read("nrdy0_0", 32'h14, 32'd0, RESP_OKAY);
        axi_read("hsk1_0", 32'h18, 32'd0, RESP_OKAY);
        axi_read("nrdy1_10", 32'h1C, 32'd10, RESP_OKAY);
        axi_read("proccnt_10", 32'h0C, 32'd10, RESP_OKAY);

        // Read-only and unmapped accesses
        axi_write("wr_proccnt", 32'h0C, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
        axi_write("wr_hsk0", 32'h10, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
        axi_write("wr_unmapped", 32'h40, 32'hFFFF_FFFF, 4'hF, RESP_SLVERR);
        axi_read("rd_unmapped", 32'h40, 32'd0, RESP_SLVERR);
        axi_read("rd_ch2", 32'h20, 32'd0, RESP_SLVERR);
        axi_read("proccnt_kept", 32'h0C, 32'd10, RESP_OKAY);
        axi_read("upstat_kept", 32'h00, 32'h3, RESP_OKAY);

        // Saturation at 255
        processing = 1'b1;
        repeat (300) tick();
        processing = 1'b0;
        axi_read("hsk0_sat", 32'h10, 32'd255, RESP_OKAY);
        axi_read("nrdy1_sat", 32'h1C, 32'd255, RESP_OKAY);
        axi_read("proccnt_sat", 32'h0C, 32'd255, RESP_OKAY);
        axi_read("nrdy0_sat0", 32'h14, 32'd0, RESP_OKAY);
        repeat (5) tick();
        axi_read("hsk0_held", 32'h10, 32'd255, RESP_OKAY);

        // Clearing up_end clears idle counters
        axi_write("upstat_byte0", 32'h00, 32'h1, 4'h1, RESP_OKAY);
        axi_read("upstat_after_b0", 32'h00, 32'h1, RESP_OKAY);
        axi_read("hsk0_clr", 32'h10, 32'd0, RESP_OKAY);
        axi_read("nrdy1_clr", 32'h1C, 32'd0, RESP_OKAY);
        axi_read("proccnt_clr", 32'h0C, 32'd0, RESP_OKAY);

        // Reset while a write response is pending
        axi_write("upstat_pre_rst", 32'h00, 32'h3, 4'hF, RESP_OKAY);
        s_axi_bready = 1'b0;
        s_axi_awaddr = 32'h00; s_axi_awvalid = 1'b1;
        s_axi_wdata = 32'h7; s_axi_wstrb = 4'hF; s_axi_wvalid = 1'b1;
        tick();
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0;
        n = 0;
        while (!s_axi_bvalid && n < 20) begin
            tick();
            n++;
        end
        check("pend_bvalid", {31'd0, s_axi_bvalid}, 32'd1);
        repeat (3) tick();
        check("pend_bvalid_held", {31'd0, s_axi_bvalid}, 32'd1);
        check("pend_wbusy", {31'd0, pl_wbusy}, 32'd1);
        check("pre_rst_irq", {31'd0, irq}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("in_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);
        check("in_rst_awready", {31'd0, s_axi_awready}, 32'd0);
        check("in_rst_arready", {31'd0, s_axi_arready}, 32'd0);
        check("in_rst_irq", {31'd0, irq}, 32'd0);
        check("in_rst_up_end", {31'd0, up_end}, 32'd0);
        check("in_rst_bresp", {30'd0, s_axi_bresp}, 32'd0);
        check("in_rst_rdata", s_axi_rdata, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        s_axi_bready = 1'b1;
        tick();
        axi_read("post_rst_upstat", 32'h00, 32'd0, RESP_OKAY);
        axi_read("post_rst_inten", 32'h04, 32'd0, RESP_OKAY);
        axi_read("post_rst_intstat", 32'h08, 32'd0, RESP_OKAY);
        axi_read("post_rst_proccnt", 32'h0C, 32'd0, RESP_OKAY);
        axi_read("post_rst_nrdy1", 32'h1C, 32'd0, RESP_OKAY);
        check("post_rst_bvalid", {31'd0, s_axi_bvalid}, 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
